// File: rtl/fp_soc_usb_irq_pio.sv
// Avalon-MM input PIO: synchronised level read, sticky per-bit edge capture, maskable level irq.
// Latency: in_port to DATA 2 edges, to EDGECAPTURE 3 edges, to irq 4 edges; reads are combinational.
// Backpressure: none; every access completes in the cycle it is presented.
module fp_soc_usb_irq_pio #(
  parameter int WIDTH     = 1,
  parameter int EDGE_TYPE = 0   // 0 = rising, 1 = falling, 2 = any
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_s3;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic             r_irq;

  logic             w_wr;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_edge;
  logic [31:0]      w_rdata;
  logic             w_unused_wdata;

  assign w_wr  = chipselect & ~write_n;
  assign w_clr = (w_wr && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

  // Upper writedata bits have no destination when WIDTH < 32.
  assign w_unused_wdata = &{1'b0, writedata};

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Edge selection is fixed at elaboration; s3 is the previous synchronised level.
  always_comb begin
    w_edge = '0;
    if (EDGE_TYPE == 0) begin
      w_edge = r_s2 & ~r_s3;
    end else if (EDGE_TYPE == 1) begin
      w_edge = ~r_s2 & r_s3;
    end else begin
      w_edge = r_s2 ^ r_s3;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
    end else if (w_wr && (address == 2'd2)) begin
      r_mask <= writedata[WIDTH-1:0];
    end
  end

  // Sticky capture flags; a new edge wins over a same-cycle write-1-to-clear so no edge is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap <= '0;
    end else begin
      r_cap <= w_edge | (r_cap & ~w_clr);
    end
  end

  // Registered level interrupt from any unmasked flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_cap & r_mask);
    end
  end

  // Zero-wait-state read mux; DIRECTION and unused upper bits read as zero.
  always_comb begin
    w_rdata = '0;
    case (address)
      2'd0:    w_rdata[WIDTH-1:0] = r_s2;
      2'd2:    w_rdata[WIDTH-1:0] = r_mask;
      2'd3:    w_rdata[WIDTH-1:0] = r_cap;
      default: w_rdata = '0;
    endcase
  end

  assign readdata = w_rdata;
  assign irq      = r_irq;

endmodule
